// File: rtl/smc_seq_ctrl_pkg.sv
// smc_pkg: shared types and constants for the serial Super MOSFET Calculator
// sequencer (smc_seq_ctrl).
//
// Contents:
//   state_e      - sequencer states IDLE / LOAD / CALC
//   N_DEV        - devices per frame (fixed at 6)
//   VAL_W/OUT_W  - per-device result width and frame result width
//   WGT_A/B/C    - weights 3/4/5 applied to the selected three results
//   frameSum()   - weighted or plain sum of three sorted results
//
// Optional feature macro: SMC_GAP_TIMEOUT_EN (adds TIMEOUT_CYC and GAP_W).
package smc_pkg;

  localparam int N_DEV = 6;
  localparam int VAL_W = 7;
  localparam int OUT_W = 10;
  localparam int CNT_W = 3;

`ifdef SMC_GAP_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 15;
  localparam int GAP_W       = 4;
`endif

  localparam logic [OUT_W-1:0] WGT_A = OUT_W'(3);
  localparam logic [OUT_W-1:0] WGT_B = OUT_W'(4);
  localparam logic [OUT_W-1:0] WGT_C = OUT_W'(5);

  typedef enum logic [1:0] {IDLE, LOAD, CALC} state_e;

  // Worst case 3*84 + 4*84 + 5*84 = 1008 still fits in OUT_W bits.
  function automatic logic [OUT_W-1:0] frameSum(
    input logic [VAL_W-1:0] a,
    input logic [VAL_W-1:0] b,
    input logic [VAL_W-1:0] c,
    input logic             weighted
  );
    logic [OUT_W-1:0] ax;
    logic [OUT_W-1:0] bx;
    logic [OUT_W-1:0] cx;
    ax = OUT_W'(a);
    bx = OUT_W'(b);
    cx = OUT_W'(c);
    if (weighted) return ax * WGT_A + bx * WGT_B + cx * WGT_C;
    else          return ax + bx + cx;
  endfunction

endpackage

// File: rtl/smc_seq_ctrl_if.sv
// smc_seq_ctrl_if: beat input and frame result bundle of the sequencer.
//
// Signals:
//   in_valid/in_ready     - beat handshake (beat taken when both high)
//   mode[1:0]             - [0]=1 ID, 0 gm; [1]=1 largest three, 0 smallest
//   W, V_GS, V_DS         - device parameters, 1..7
//   out_valid, out_n      - one-cycle result strobe and held frame result
//   err_timeout           - one-cycle frame-abort strobe
//
// Modports: master drives beats (testbench / upstream), slave is the sequencer.
// Optional feature macro: SMC_GAP_TIMEOUT_EN (affects err_timeout only).
interface smc_seq_ctrl_if;
  import smc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [2:0]       W;
  logic [2:0]       V_GS;
  logic [2:0]       V_DS;
  logic             out_valid;
  logic [OUT_W-1:0] out_n;
  logic             err_timeout;

  modport master (
    output in_valid, mode, W, V_GS, V_DS,
    input  in_ready, out_valid, out_n, err_timeout
  );

  modport slave (
    input  in_valid, mode, W, V_GS, V_DS,
    output in_ready, out_valid, out_n, err_timeout
  );

endinterface

// File: rtl/smc_seq_ctrl_dev_calc.sv
// smc_dev_calc: combinational ID / gm evaluation for one device beat.
//
// Ports:
//   w_i, vgs_i, vds_i - device parameters, valid range 1..7
//   selId_i           - 1 selects drain current ID, 0 selects gm
//   val_o             - truncated result divided by 3, VAL_W bits
//
// Out-of-range inputs (0) give a meaningless result; nothing guards them.
// Optional feature macro: SMC_GAP_TIMEOUT_EN (no effect in this file).
module smc_dev_calc
  import smc_pkg::*;
(
  input  logic [2:0]       w_i,
  input  logic [2:0]       vgs_i,
  input  logic [2:0]       vds_i,
  input  logic             selId_i,
  output logic [VAL_W-1:0] val_o
);

  logic [15:0] w;
  logic [15:0] vgs;
  logic [15:0] vds;
  logic [15:0] prod;
  logic        triode;

  assign w   = 16'(w_i);
  assign vgs = 16'(vgs_i);
  assign vds = 16'(vds_i);

  // Region check plus the numerator of the selected quantity; a 16-bit
  // intermediate keeps every in-range product (max 252) exact before /3.
  always_comb begin
    triode = (vgs > vds + 16'd1);
    prod   = '0;
    if (selId_i) begin
      if (triode) prod = w * vds * (16'd2 * vgs - vds - 16'd2);
      else        prod = w * (vgs - 16'd1) * (vgs - 16'd1);
    end else begin
      if (triode) prod = 16'd2 * w * vds;
      else        prod = 16'd2 * w * (vgs - 16'd1);
    end
    val_o = VAL_W'(prod / 16'd3);
  end

endmodule

// File: rtl/smc_seq_ctrl.sv
// smc_seq_ctrl: serial sequencer of the Super MOSFET Calculator. Takes six
// device beats per frame, evaluates each on one shared smc_dev_calc unit,
// insertion-sorts the results (descending) into a 6-entry array and emits one
// top-3 / bottom-3, weighted or plain, sum per frame.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - smc_seq_ctrl_if.slave (beat handshake, mode, W/V_GS/V_DS,
//          out_valid, out_n, err_timeout)
//
// Optional feature macro: SMC_GAP_TIMEOUT_EN. When defined, a frame stalled in
// LOAD for TIMEOUT_CYC consecutive cycles is dropped with an err_timeout
// strobe; when undefined err_timeout is tied low.
module smc_seq_ctrl
  import smc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  smc_seq_ctrl_if.slave bus
);

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] beatCnt_q,  beatCnt_d;
  logic [1:0]       mode_q,     mode_d;
  logic [VAL_W-1:0] sortArr_q [N_DEV];
  logic [VAL_W-1:0] sortArr_d [N_DEV];
  logic [VAL_W-1:0] insArr    [N_DEV];
  logic [OUT_W-1:0] outN_q,     outN_d;
  logic             outValid_q, outValid_d;
`ifdef SMC_GAP_TIMEOUT_EN
  logic [GAP_W-1:0] gapCnt_q,   gapCnt_d;
  logic             errTimeout_q, errTimeout_d;
`endif

  logic             inReady;
  logic             accept;
  logic             selId;
  logic [VAL_W-1:0] beatVal;

  assign inReady       = (state_q != CALC);
  assign accept        = bus.in_valid && inReady;
  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.out_n     = outN_q;
`ifdef SMC_GAP_TIMEOUT_EN
  assign bus.err_timeout = errTimeout_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  // The first beat of a frame is evaluated with the mode arriving alongside
  // it, because mode_q only captures that mode on the same edge.
  assign selId = (state_q == IDLE) ? bus.mode[0] : mode_q[0];

  smc_dev_calc u_calc (
    .w_i     (bus.W),
    .vgs_i   (bus.V_GS),
    .vds_i   (bus.V_DS),
    .selId_i (selId),
    .val_o   (beatVal)
  );

  // Insertion into the descending array: each slot keeps its value, takes the
  // new one, or inherits its upper neighbour; the bottom entry falls off.
  // Unused slots hold 0, so shifting them out never loses a real result.
  always_comb begin
    insArr[0] = (sortArr_q[0] >= beatVal) ? sortArr_q[0] : beatVal;
    for (int i = 1; i < N_DEV; i++) begin
      if (sortArr_q[i] >= beatVal)        insArr[i] = sortArr_q[i];
      else if (sortArr_q[i-1] >= beatVal) insArr[i] = beatVal;
      else                                insArr[i] = sortArr_q[i-1];
    end
  end

  // Next-state logic: frame start in IDLE, counting and sorting in LOAD, a
  // single result cycle in CALC.
  always_comb begin
    state_d      = state_q;
    beatCnt_d    = beatCnt_q;
    mode_d       = mode_q;
    sortArr_d    = sortArr_q;
    outN_d       = outN_q;
    outValid_d   = 1'b0;
`ifdef SMC_GAP_TIMEOUT_EN
    gapCnt_d     = gapCnt_q;
    errTimeout_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d       = bus.mode;
          beatCnt_d    = CNT_W'(1);
          sortArr_d[0] = beatVal;
          for (int i = 1; i < N_DEV; i++) sortArr_d[i] = '0;
          state_d      = LOAD;
`ifdef SMC_GAP_TIMEOUT_EN
          gapCnt_d     = '0;
`endif
        end
      end

      LOAD: begin
        if (accept) begin
          sortArr_d = insArr;
`ifdef SMC_GAP_TIMEOUT_EN
          gapCnt_d  = '0;
`endif
          if (beatCnt_q == CNT_W'(N_DEV - 1)) begin
            beatCnt_d = CNT_W'(N_DEV);
            state_d   = CALC;
          end else begin
            beatCnt_d = beatCnt_q + CNT_W'(1);
          end
        end
`ifdef SMC_GAP_TIMEOUT_EN
        // This idle edge is the TIMEOUT_CYC-th in a row: drop the frame.
        else if (gapCnt_q == GAP_W'(TIMEOUT_CYC - 1)) begin
          state_d      = IDLE;
          beatCnt_d    = '0;
          gapCnt_d     = '0;
          errTimeout_d = 1'b1;
        end else begin
          gapCnt_d = gapCnt_q + GAP_W'(1);
        end
`endif
      end

      CALC: begin
        if (mode_q[1]) outN_d = frameSum(sortArr_q[0], sortArr_q[1], sortArr_q[2], mode_q[0]);
        else           outN_d = frameSum(sortArr_q[3], sortArr_q[4], sortArr_q[5], mode_q[0]);
        outValid_d = 1'b1;
        beatCnt_d  = '0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any partial frame and clears the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beatCnt_q    <= '0;
      mode_q       <= '0;
      outN_q       <= '0;
      outValid_q   <= 1'b0;
      for (int i = 0; i < N_DEV; i++) sortArr_q[i] <= '0;
`ifdef SMC_GAP_TIMEOUT_EN
      gapCnt_q     <= '0;
      errTimeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      beatCnt_q    <= beatCnt_d;
      mode_q       <= mode_d;
      outN_q       <= outN_d;
      outValid_q   <= outValid_d;
      for (int i = 0; i < N_DEV; i++) sortArr_q[i] <= sortArr_d[i];
`ifdef SMC_GAP_TIMEOUT_EN
      gapCnt_q     <= gapCnt_d;
      errTimeout_q <= errTimeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// tb_smc_seq_ctrl: directed self-checking bench for smc_seq_ctrl. Every frame
// uses the common device set F (ID 84,0,5,2,26,1; gm 28,0,2,2,6,2), so the
// expected sums are 381 (mode 11), 10 (01), 36 (10) and 4 (00).
// Optional feature macro: SMC_GAP_TIMEOUT_EN selects which gap scenario runs.
module tb_smc_seq_ctrl;

  logic clk;
  logic rst;
  int   vecCount  = 0;
  int   missCount = 0;

  smc_seq_ctrl_if bus ();

  smc_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [2:0] F_W [6] = '{3'd7, 3'd1, 3'd3, 3'd2, 3'd5, 3'd4};
  localparam logic [2:0] F_G [6] = '{3'd7, 3'd1, 3'd4, 3'd3, 3'd6, 3'd2};
  localparam logic [2:0] F_D [6] = '{3'd7, 3'd1, 3'd1, 3'd3, 3'd2, 3'd5};

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present beat idx of F from the falling edge; it is sampled on the next rise.
  task automatic sendBeat(input int idx, input logic [1:0] m);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.W        = F_W[idx];
    bus.V_GS     = F_G[idx];
    bus.V_DS     = F_D[idx];
    bus.mode     = m;
    @(posedge clk);
  endtask

  task automatic idleCycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
  endtask

  // Whole frame F; firstMode on beat 1, laterMode on beats 2-6, gap idle
  // cycles between beats.
  task automatic sendFrame(input logic [1:0] firstMode, input logic [1:0] laterMode,
                           input int gap);
    for (int i = 0; i < 6; i++) begin
      sendBeat(i, (i == 0) ? firstMode : laterMode);
      if (i < 5) repeat (gap) idleCycle();
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.mode     = 2'b00;
    bus.W        = 3'd1;
    bus.V_GS     = 3'd1;
    bus.V_DS     = 3'd1;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecCount++;
    if (bus.in_ready !== 1'b1) begin
      missCount++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    vecCount++;
    if (bus.out_valid !== 1'b0) begin
      missCount++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    vecCount++;
    if (bus.out_n !== 10'd0) begin
      missCount++; $display("[TB] FAIL reset_out_n: got %0d expected 0", bus.out_n);
    end
    vecCount++;
    if (bus.err_timeout !== 1'b0) begin
      missCount++; $display("[TB] FAIL reset_err_timeout: got %b expected 0", bus.err_timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    sendFrame(2'b11, 2'b11, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    vecCount++;
    if (bus.in_ready !== 1'b0) begin
      missCount++; $display("[TB] FAIL calc_in_ready: got %b expected 0", bus.in_ready);
    end
    vecCount++;
    if (bus.out_valid !== 1'b0) begin
      missCount++; $display("[TB] FAIL calc_early_valid: got %b expected 0", bus.out_valid);
    end
    @(posedge clk); #1;
    vecCount++;
    if (bus.out_valid !== 1'b1) begin
      missCount++; $display("[TB] FAIL single_out_valid: got %b expected 1", bus.out_valid);
    end
    vecCount++;
    if (bus.out_n !== 10'd381) begin
      missCount++; $display("[TB] FAIL single_out_n: got %0d expected 381", bus.out_n);
    end
    @(posedge clk); #1;
    vecCount++;
    if (bus.out_valid !== 1'b0) begin
      missCount++; $display("[TB] FAIL single_pulse_len: got %b expected 0", bus.out_valid);
    end
    vecCount++;
    if (bus.out_n !== 10'd381) begin
      missCount++; $display("[TB] FAIL single_hold: got %0d expected 381", bus.out_n);
    end
  endtask

  // Next frame's first beat is driven in the cycle where out_valid is high.
  task automatic test_back_to_back();
    logic [1:0] modes [3];
    logic [9:0] exps  [3];
    modes = '{2'b01, 2'b10, 2'b00};
    exps  = '{10'd10, 10'd36, 10'd4};
    for (int f = 0; f < 3; f++) begin
      sendFrame(modes[f], modes[f], 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      vecCount++;
      if (bus.out_valid !== 1'b1) begin
        missCount++; $display("[TB] FAIL b2b_valid_%0d: got %b expected 1", f, bus.out_valid);
      end
      vecCount++;
      if (bus.out_n !== exps[f]) begin
        missCount++; $display("[TB] FAIL b2b_out_n_%0d: got %0d expected %0d", f, bus.out_n, exps[f]);
      end
      vecCount++;
      if (bus.in_ready !== 1'b1) begin
        missCount++; $display("[TB] FAIL b2b_ready_%0d: got %b expected 1", f, bus.in_ready);
      end
    end
    @(posedge clk); #1;
    vecCount++;
    if (bus.out_valid !== 1'b0) begin
      missCount++; $display("[TB] FAIL b2b_idle_valid: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_gaps_mode();
    sendFrame(2'b11, 2'b00, 3);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    vecCount++;
    if (bus.out_valid !== 1'b1) begin
      missCount++; $display("[TB] FAIL gaps_valid: got %b expected 1", bus.out_valid);
    end
    vecCount++;
    if (bus.out_n !== 10'd381) begin
      missCount++; $display("[TB] FAIL gaps_out_n: got %0d expected 381", bus.out_n);
    end
  endtask

  task automatic test_reset_mid_frame();
    int ovSeen;
    for (int i = 0; i < 4; i++) sendBeat(i, 2'b11);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    vecCount++;
    if (bus.out_n !== 10'd0) begin
      missCount++; $display("[TB] FAIL midrst_out_n: got %0d expected 0", bus.out_n);
    end
    vecCount++;
    if (bus.in_ready !== 1'b1) begin
      missCount++; $display("[TB] FAIL midrst_ready: got %b expected 1", bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    ovSeen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) ovSeen++;
    end
    vecCount++;
    if (ovSeen !== 0) begin
      missCount++; $display("[TB] FAIL midrst_no_output: got %0d pulses expected 0", ovSeen);
    end
    sendFrame(2'b10, 2'b10, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    vecCount++;
    if (bus.out_valid !== 1'b1) begin
      missCount++; $display("[TB] FAIL midrst_valid: got %b expected 1", bus.out_valid);
    end
    vecCount++;
    if (bus.out_n !== 10'd36) begin
      missCount++; $display("[TB] FAIL midrst_out_n2: got %0d expected 36", bus.out_n);
    end
  endtask

  task automatic test_gap_timeout();
    int errPulses;
    int errIdx;
    int ovSeen;
    errPulses = 0;
    errIdx    = 0;
    ovSeen    = 0;
    for (int i = 0; i < 3; i++) sendBeat(i, 2'b11);
    @(negedge clk);
    bus.in_valid = 1'b0;
`ifdef SMC_GAP_TIMEOUT_EN
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.err_timeout === 1'b1) begin errPulses++; errIdx = k; end
      if (bus.out_valid === 1'b1) ovSeen++;
    end
    vecCount++;
    if (errPulses !== 1) begin
      missCount++; $display("[TB] FAIL timeout_pulses: got %0d expected 1", errPulses);
    end
    vecCount++;
    if (errIdx !== 15) begin
      missCount++; $display("[TB] FAIL timeout_cycle: got %0d expected 15", errIdx);
    end
    vecCount++;
    if (ovSeen !== 0) begin
      missCount++; $display("[TB] FAIL timeout_no_output: got %0d expected 0", ovSeen);
    end
    sendFrame(2'b11, 2'b11, 0);
`else
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (bus.err_timeout === 1'b1) errPulses++;
      if (bus.out_valid === 1'b1) ovSeen++;
    end
    vecCount++;
    if (errPulses !== 0) begin
      missCount++; $display("[TB] FAIL notimeout_pulses: got %0d expected 0", errPulses);
    end
    vecCount++;
    if (ovSeen !== 0) begin
      missCount++; $display("[TB] FAIL notimeout_no_output: got %0d expected 0", ovSeen);
    end
    for (int i = 3; i < 6; i++) sendBeat(i, 2'b00);
`endif
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    vecCount++;
    if (bus.out_valid !== 1'b1) begin
      missCount++; $display("[TB] FAIL gap_final_valid: got %b expected 1", bus.out_valid);
    end
    vecCount++;
    if (bus.out_n !== 10'd381) begin
      missCount++; $display("[TB] FAIL gap_final_out_n: got %0d expected 381", bus.out_n);
    end
  endtask

  // Scenario sequence; each task leaves the sequencer idle for the next.
  initial begin
    $display("[TB] smc_seq_ctrl directed test start");
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gaps_mode();
    test_reset_mid_frame();
    test_gap_timeout();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
